// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit feeding the HI/LO registers.
// Shift-add multiply and restoring divide run on unsigned magnitudes; signs are applied in FIX.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] COUNT_ONE  = CNT_W'(1);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_count;
  logic               r_isDiv;
  logic               r_negRes;
  logic               r_negRem;
  logic               r_dz;
  logic [WIDTH-1:0]   r_operand;
  logic [WIDTH-1:0]   r_accHi;
  logic [WIDTH-1:0]   r_accLo;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dzOut;

  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [WIDTH:0]     w_multSum;
  logic [WIDTH:0]     w_shRem;
  logic [WIDTH-1:0]   w_diff;
  logic               w_fits;
  logic [2*WIDTH-1:0] w_product;
  logic [2*WIDTH-1:0] w_signedProd;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  // Negating the most negative value wraps to itself, which is exactly its unsigned magnitude.
  assign w_absA = a[WIDTH-1] ? -a : a;
  assign w_absB = b[WIDTH-1] ? -b : b;

  // Multiply: accHi is the running upper half, accLo holds the multiplier shifting out.
  assign w_multSum = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, r_operand} : '0);

  // Divide: accHi is the partial remainder, accLo the dividend turning into the quotient.
  assign w_shRem = {r_accHi, r_accLo[WIDTH-1]};
  assign w_fits  = (w_shRem >= {1'b0, r_operand});
  assign w_diff  = w_shRem[WIDTH-1:0] - r_operand;

  assign w_product    = {r_accHi, r_accLo};
  assign w_signedProd = r_negRes ? -w_product : w_product;
  assign w_quo        = r_negRes ? -r_accLo : r_accLo;
  assign w_rem        = r_negRem ? -r_accHi : r_accHi;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_dz      <= 1'b0;
      r_operand <= '0;
      r_accHi   <= '0;
      r_accLo   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_dzOut   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_dzOut <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mult_start || div_start) begin
            r_isDiv  <= ~mult_start;
            r_negRes <= a[WIDTH-1] ^ b[WIDTH-1];
            r_negRem <= a[WIDTH-1];
            r_count  <= LAST_COUNT;
            r_accHi  <= '0;
            if (mult_start) begin
              r_operand <= w_absA;
              r_accLo   <= w_absB;
              r_dz      <= 1'b0;
              r_state   <= S_RUN;
            end else begin
              r_operand <= w_absB;
              r_accLo   <= w_absA;
              r_dz      <= (b == '0);
              r_state   <= (b == '0) ? S_FIX : S_RUN;
            end
          end
        end
        S_RUN: begin
          if (r_isDiv) begin
            r_accHi <= w_fits ? w_diff : w_shRem[WIDTH-1:0];
            r_accLo <= {r_accLo[WIDTH-2:0], w_fits};
          end else begin
            r_accHi <= w_multSum[WIDTH:1];
            r_accLo <= {w_multSum[0], r_accLo[WIDTH-1:1]};
          end
          r_count <= r_count - COUNT_ONE;
          if (r_count == '0) r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_dz) begin
            if (r_isDiv) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_signedProd[2*WIDTH-1:WIDTH];
              r_lo <= w_signedProd[WIDTH-1:0];
            end
          end
          r_done  <= 1'b1;
          r_dzOut <= r_dz;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == S_RUN) || (r_state == S_FIX);
  assign done        = r_done;
  assign div_by_zero = r_dzOut;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
